riscv_fetch: RTL and testbench

Instruction fetch unit between `program_counter` and the decoder. It accepts a fetch address from the PC side over a valid/ready handshake and issues one word read to instruction memory over a request/grant/response bus. Returned words, tagged with their PC, are buffered in a small FIFO and presented to the decoder over valid/ready. A flush input discards all buffered and in-flight fetches on branch/jump redirect.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/riscv_fetch.sv | 117 +++++++++++
 tb/tb_riscv_fetch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the instruction fetch path: FSM states and the FIFO entry
// that carries a fetched word (or a misalignment fault) with its PC.
package riscv_pkg;
    localparam int PC_W            = 32;
    localparam int INST_WORD_BYTES = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;

    typedef struct packed {
        logic            fault;
        logic [PC_W-1:0] pc;
        logic [31:0]     data;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; head is read straight from storage.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               clear_i,
    input  logic [ENTRY_W-1:0] din_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o,
    output logic [ENTRY_W-1:0] head_o
);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop     = pop_i && !empty_o;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= fetch_entry_t'(din_i);
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_i && !pop)      count_q <= count_q + 1'b1;
            else if (!push_i && pop) count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch unit: PC handshake in, single-outstanding memory read,
// buffered instruction words out to the decoder, flush on redirect.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_valid_i,
    input  logic [ADDR_SIZE-1:0] pc_addr_i,
    output logic                 pc_ready_o,
    input  logic                 flush_i,
    output logic                 mem_req_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 inst_valid_o,
    input  logic                 inst_ready_i,
    output logic [31:0]          inst_data_o,
    output logic [ADDR_SIZE-1:0] inst_pc_o,
    output logic                 inst_fault_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'(INST_WORD_BYTES - 1);

    fetch_state_t         state_q;
    logic                 mem_req_q, drop_q;
    logic [ADDR_SIZE-1:0] mem_addr_q;

    logic                 accept, misaligned, fault_push, resp_push, push, pop;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;
    fetch_entry_t         push_entry, head;
    logic [ENTRY_W-1:0]   head_raw;

    assign misaligned = (pc_addr_i & ALIGN_MASK) != '0;
    assign pc_ready_o = !rst && (state_q == IDLE) && (fifo_count < CW'(DEPTH)) && !flush_i;
    assign accept     = pc_valid_i && pc_ready_o;
    assign fault_push = accept && misaligned;
    // A flush in the response cycle discards the word even before drop_q is set.
    assign resp_push  = (state_q == WAIT) && mem_rvalid_i && !drop_q && !flush_i;
    assign push       = fault_push || resp_push;
    assign pop        = inst_valid_o && inst_ready_i;

    always_comb begin
        push_entry = '0;
        if (fault_push) begin
            push_entry.fault = 1'b1;
            push_entry.pc    = PC_W'(pc_addr_i);
        end else begin
            push_entry.pc    = PC_W'(mem_addr_q);
            push_entry.data  = mem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept && !misaligned) begin
                    state_q    <= REQ;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= pc_addr_i & ~ALIGN_MASK;
                end
                // The request is never withdrawn; a flush only marks its response dead.
                REQ: begin
                    if (flush_i) drop_q <= 1'b1;
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end else if (flush_i) begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full && !pop));
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .din_i   (push_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head_raw)
    );

    assign head         = fetch_entry_t'(head_raw);
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign inst_valid_o = !fifo_empty;
    assign inst_data_o  = head.data;
    assign inst_pc_o    = ADDR_SIZE'(head.pc);
    assign inst_fault_o = head.fault;
endmodule

// File: tb/tb_riscv_fetch.sv
// Directed plus randomized bench for riscv_fetch against a queue-based model.
module tb_riscv_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid, pc_ready, flush;
    logic [31:0] pc_addr;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst_data, inst_pc;

    riscv_fetch #(.ADDR_SIZE(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_valid_i   (pc_valid),
        .pc_addr_i    (pc_addr),
        .pc_ready_o   (pc_ready),
        .flush_i      (flush),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .inst_data_o  (inst_data),
        .inst_pc_o    (inst_pc),
        .inst_fault_o (inst_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic [31:0] pc;
        logic [31:0] d;
    } ent_t;

    // Model: what the decoder should see, plus whether a fetch is in flight.
    ent_t        q[$];
    bit          outstanding, granted, dropped;
    logic [31:0] cur_addr;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the negedge, check everything, advance the model.
    task automatic step(input logic pv, input logic [31:0] pa, input logic ir,
                        input logic fl, input logic gnt, input logic rv,
                        input logic [31:0] rd);
        bit   exp_rdy, acc, rv_eff, gnt_eff;
        ent_t e;
        pc_valid = pv; pc_addr = pa; inst_ready = ir; flush = fl;
        mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd;
        #1;
        exp_rdy = !outstanding && (q.size() < DEPTH) && !fl;
        chk("pc_ready", pc_ready, exp_rdy);
        chk("mem_req", mem_req, outstanding && !granted);
        if (outstanding && !granted) chk("mem_addr", mem_addr, cur_addr);
        chk("inst_valid", inst_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst_data", inst_data, q[0].d);
            chk("inst_fault", inst_fault, q[0].f);
        end
        acc     = pv && exp_rdy;
        rv_eff  = rv && outstanding && granted;
        gnt_eff = gnt && outstanding && !granted;
        if (fl) begin
            q.delete();
            if (outstanding) dropped = 1;
        end else if (q.size() != 0 && ir) begin
            void'(q.pop_front());
        end
        if (rv_eff) begin
            if (!dropped && !fl) begin
                e.f = 1'b0; e.pc = cur_addr; e.d = rd;
                q.push_back(e);
            end
            outstanding = 0; granted = 0; dropped = 0;
        end
        if (gnt_eff) granted = 1;
        if (acc) begin
            if (pa[1:0] != 2'b00) begin
                e.f = 1'b1; e.pc = pa; e.d = 32'h0;
                q.push_back(e);
            end else begin
                outstanding = 1; cur_addr = pa;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ir);
        step(1'b0, 32'h0, ir, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; pc_valid = 1'b1; pc_addr = 32'h4; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b0;
        outstanding = 0; granted = 0; dropped = 0; cur_addr = 32'h0;

        // Reset held two cycles with pc_valid high
        repeat (2) begin
            @(negedge clk);
            chk("rst_pc_ready", pc_ready, 1'b0);
            chk("rst_mem_req", mem_req, 1'b0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_inst_valid", inst_valid, 1'b0);
            chk("rst_inst_word", {inst_fault, inst_pc, inst_data}, 65'h0);
        end
        rst = 1'b0; pc_valid = 1'b0;
        #1 chk("rel_pc_ready", pc_ready, 1'b1);

        // Basic fetch, zero-wait memory
        step(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("basic_addr", mem_addr, 32'h4);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093);
        chk("basic_valid", inst_valid, 1'b1);
        chk("basic_pc", inst_pc, 32'h4);
        chk("basic_data", inst_data, 32'h00500093);
        idle(1'b1);

        // Backpressure: two entries fill the FIFO, third fetch stalls
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 32'h4 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            step(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000 + 32'(k));
        end
        repeat (3) begin
            step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("bp_ready", pc_ready, 1'b0);
        end
        chk("bp_head0", inst_pc, 32'h4);
        idle(1'b1);
        chk("bp_head1", inst_pc, 32'h8);
        idle(1'b1);
        chk("bp_empty", inst_valid, 1'b0);

        // Misaligned fetch becomes a fault entry without touching memory
        step(1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("mis_req", mem_req, 1'b0);
        chk("mis_fault", inst_fault, 1'b1);
        chk("mis_pc", inst_pc, 32'h6);
        chk("mis_data", inst_data, 32'h0);
        idle(1'b1);

        // Flush while waiting for the response
        step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("fw_dropped", inst_valid, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678);
        chk("fw_next_pc", inst_pc, 32'h40);
        chk("fw_next_data", inst_data, 32'h12345678);
        idle(1'b1);

        // Delayed grant with a flush during REQ
        step(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h24, 1'b1, (k == 1), 1'b0, 1'b0, 32'h0);
            chk("dg_req", mem_req, 1'b1);
            chk("dg_addr", mem_addr, 32'h20);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        chk("dg_dropped", inst_valid, 1'b0);

        // Flush in the same cycle as the response
        step(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hBAD0BAD0);
        chk("fr_dropped", inst_valid, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            a = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
